// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debounce bank.
`default_nettype none

package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    REPEAT   = 2'd2
  } key_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce counter, press/hold/repeat FSM.
`default_nettype none

module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_W = 14,
  parameter int HOLD_W     = 22,
  parameter int RATE_W     = 20,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic out_o,
  output logic rising_o,
  output logic falling_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int CNT_W = max_w(HOLD_W, RATE_W);
  localparam logic [DEBOUNCE_W-1:0] DEB_MAX  = '1;
  localparam logic [CNT_W-1:0]      HOLD_MAX = CNT_W'({HOLD_W{1'b1}});
  localparam logic [CNT_W-1:0]      RATE_MAX = CNT_W'({RATE_W{1'b1}});

  logic [1:0]            sync_q;
  logic                  in_s;
  logic                  out_q, out_d;
  logic [DEBOUNCE_W-1:0] deb_cnt_q, deb_cnt_d;
  key_state_e            state_q, state_d;
  logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  lp_q, lp_d;
  logic                  rep_q, rep_d;
  logic                  press_evt, release_evt;

  assign in_s = sync_q[1];

  always_comb begin
    out_d     = out_q;
    deb_cnt_d = '0;
    if (in_s != out_q) begin
      if (deb_cnt_q == DEB_MAX) begin
        out_d = in_s;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Events are taken from out_d so the FSM and edge pulses move on the same edge as out.
  assign press_evt   = (out_q == IDLE_LEVEL) && (out_d != IDLE_LEVEL);
  assign release_evt = (out_q != IDLE_LEVEL) && (out_d == IDLE_LEVEL);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    lp_d       = 1'b0;
    rep_d      = 1'b0;
    rise_d     = release_evt;
    fall_d     = press_evt;
    if (release_evt) begin
      // Release beats any terminal count reached on this edge.
      state_d    = RELEASED;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        RELEASED: begin
          if (press_evt) begin
            state_d    = PRESSED;
            hold_cnt_d = '0;
          end
        end
        PRESSED: begin
          if (hold_cnt_q == HOLD_MAX) begin
            state_d    = REPEAT;
            hold_cnt_d = '0;
            lp_d       = 1'b1;
            rep_d      = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (hold_cnt_q == RATE_MAX) begin
            hold_cnt_d = '0;
            rep_d      = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = RELEASED;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= {2{IDLE_LEVEL}};
      out_q      <= IDLE_LEVEL;
      deb_cnt_q  <= '0;
      state_q    <= RELEASED;
      hold_cnt_q <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      lp_q       <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], in_i};
      out_q      <= out_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      lp_q       <= lp_d;
      rep_q      <= rep_d;
    end
  end

  assign out_o        = out_q;
  assign rising_o     = rise_q;
  assign falling_o    = fall_q;
  assign long_press_o = lp_q;
  assign repeat_o     = rep_q;

endmodule

`default_nettype wire

// File: rtl/key_debounce_bank.sv
// Bank of independent debounced keys with long-press, auto-repeat and a shared event flag.
`default_nettype none

module key_debounce_bank
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int DEBOUNCE_W = 14,
  parameter int HOLD_W     = 22,
  parameter int RATE_W     = 20,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] in_i,
  output logic [NUM_KEYS-1:0] out_o,
  output logic [NUM_KEYS-1:0] rising_o,
  output logic [NUM_KEYS-1:0] falling_o,
  output logic [NUM_KEYS-1:0] long_press_o,
  output logic [NUM_KEYS-1:0] repeat_o,
  output logic                any_event_o
);

  logic any_event_q, any_event_d;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_W (DEBOUNCE_W),
      .HOLD_W     (HOLD_W),
      .RATE_W     (RATE_W),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_i         (in_i[k]),
      .out_o        (out_o[k]),
      .rising_o     (rising_o[k]),
      .falling_o    (falling_o[k]),
      .long_press_o (long_press_o[k]),
      .repeat_o     (repeat_o[k])
    );
  end

  // Pulses are already registered, so this flags the previous cycle's events.
  assign any_event_d = |{rising_o, falling_o, long_press_o, repeat_o};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_event_q <= 1'b0;
    end else begin
      any_event_q <= any_event_d;
    end
  end

  assign any_event_o = any_event_q;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench: spec-level model pushes expected outputs, monitor pops and compares.
`default_nettype none

module tb_key_debounce_bank;

  localparam int NK   = 4;
  localparam int DW   = 2;
  localparam int HW   = 3;
  localparam int RW   = 2;
  localparam int WIN  = 1 << DW;
  localparam int HOLD = 1 << HW;
  localparam int RATE = 1 << RW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] in_i;
  logic [NK-1:0] out_o, rising_o, falling_o, long_press_o, repeat_o;
  logic          any_event_o;

  key_debounce_bank #(
    .NUM_KEYS   (NK),
    .DEBOUNCE_W (DW),
    .HOLD_W     (HW),
    .RATE_W     (RW),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_i         (in_i),
    .out_o        (out_o),
    .rising_o     (rising_o),
    .falling_o    (falling_o),
    .long_press_o (long_press_o),
    .repeat_o     (repeat_o),
    .any_event_o  (any_event_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NK-1:0] out;
    logic [NK-1:0] rise;
    logic [NK-1:0] fall;
    logic [NK-1:0] lp;
    logic [NK-1:0] rep;
    logic          any;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: pin delayed two edges, out flips once the last WIN synchronised
  // samples all disagree with it, pulses derived from the age of the current press.
  logic [NK-1:0] s1_m, s2_m, out_m;
  logic [15:0]   hist [NK];
  int            age  [NK];
  logic          pend_m;
  exp_t          e;

  always @(posedge clk) begin
    e = '0;
    if (!rst_n) begin
      s1_m   = '1;
      s2_m   = '1;
      out_m  = '1;
      pend_m = 1'b0;
      for (int k = 0; k < NK; k++) begin
        hist[k] = '1;
        age[k]  = 0;
      end
      e.out = '1;
    end else begin
      for (int k = 0; k < NK; k++) begin
        logic flip;
        hist[k] = {hist[k][14:0], s2_m[k]};
        flip = (hist[k][WIN-1:0] == {WIN{~out_m[k]}});
        if (flip) out_m[k] = ~out_m[k];
        e.rise[k] = flip && out_m[k];
        e.fall[k] = flip && !out_m[k];
        if (e.fall[k]) age[k] = 0;
        else if (!out_m[k]) age[k] = age[k] + 1;
        if (!out_m[k] && !e.fall[k]) begin
          e.lp[k]  = (age[k] == HOLD);
          e.rep[k] = (age[k] >= HOLD) && (((age[k] - HOLD) % RATE) == 0);
        end
      end
      s2_m   = s1_m;
      s1_m   = in_i;
      e.out  = out_m;
      e.any  = pend_m;
      pend_m = |{e.rise, e.fall, e.lp, e.rep};
    end
    sb.push_back(e);
  end

  task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty t=%0t actual=0 expected=1", $time);
    end else begin
      x = sb.pop_front();
      chk("out",        out_o,                 x.out);
      chk("rising",     rising_o,              x.rise);
      chk("falling",    falling_o,             x.fall);
      chk("long_press", long_press_o,          x.lp);
      chk("repeat",     repeat_o,              x.rep);
      chk("any_event",  {{(NK-1){1'b0}}, any_event_o}, {{(NK-1){1'b0}}, x.any});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [NK-1:0] mask, input int hold, input int gap);
    in_i = in_i & ~mask;
    cyc(hold);
    in_i = in_i | mask;
    cyc(gap);
  endtask

  initial begin
    rst_n = 1'b0;
    in_i  = '1;
    cyc(3);
    rst_n = 1'b1;
    cyc(4);
    press(4'b0001, 12, 12);
    press(4'b0010, 3, 12);
    press(4'b0001, 30, 14);
    for (int h = 20; h < 28; h++) press(4'b0100, h, 12);
    in_i[2] = 1'b0;
    cyc(25);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    in_i[2] = 1'b1;
    cyc(12);
    press(4'b1111, 15, 12);
    for (int i = 0; i < 1600; i++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, (i < 600) ? 5 : 40) == 0) in_i[k] = ~in_i[k];
      end
      if ($urandom_range(0, 500) == 0) begin
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
      cyc(1);
    end
    in_i = '1;
    cyc(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_debounce_bank.md
KEY_DEBOUNCE_BANK -- requirements
Module: key_debounce_bank

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4, number of independent input channels.
REQ-002 SHALL have parameter DEBOUNCE_W, default 14 (SIM: 2), stability window of 2**DEBOUNCE_W cycles.
REQ-003 SHALL have parameter HOLD_W, default 22 (SIM: 3), long-press threshold of 2**HOLD_W cycles.
REQ-004 SHALL have parameter RATE_W, default 20 (SIM: 2), auto-repeat period of 2**RATE_W cycles.
REQ-005 SHALL have parameter IDLE_LEVEL, default 1, released level of the pins (pressed = opposite level).
REQ-006 SHALL have clk  input  1  single clock for all logic.
REQ-007 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have in  input  NUM_KEYS  raw asynchronous pins.
REQ-009 SHALL have out  output  NUM_KEYS  debounced level per channel.
REQ-010 SHALL have rising, falling  output  NUM_KEYS  one-cycle edge pulses of out.
REQ-011 SHALL have long_press  output  NUM_KEYS  one-cycle pulse when hold threshold is reached.
REQ-012 SHALL have repeat  output  NUM_KEYS  one-cycle auto-repeat pulses while held.
REQ-013 SHALL have any_event  output  1  registered OR of all pulse outputs of the previous cycle, for interrupt use.

Function
REQ-014 Each in bit SHALL pass through a 2-flop synchroniser; the second flop is in_s.
REQ-015 Per channel, a DEBOUNCE_W-bit counter SHALL increment each cycle in_s != out and clear to 0 whenever in_s == out.
REQ-016 When in_s != out and counter == 2**DEBOUNCE_W-1, out SHALL take in_s at that edge and counter SHALL clear.
REQ-017 A pin change held stable SHALL appear on out exactly 2**DEBOUNCE_W + 2 clock edges later.
REQ-018 Any glitch shorter than 2**DEBOUNCE_W synchronised cycles SHALL leave out unchanged.
REQ-019 rising/falling SHALL be registered, high exactly in the first cycle out holds the new value.
REQ-020 Per-channel FSM states: RELEASED, PRESSED, REPEAT.
REQ-021 RELEASED -> PRESSED on out leaving IDLE_LEVEL; hold counter cleared.
REQ-022 PRESSED: hold counter increments; at 2**HOLD_W-1 -> REPEAT, counter cleared, long_press and repeat pulsed together.
REQ-023 REPEAT: counter increments; at 2**RATE_W-1 pulse repeat, clear counter, stay in REPEAT.
REQ-024 Any state -> RELEASED on out returning to IDLE_LEVEL; release SHALL win over a same-cycle terminal count (no pulse).
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-026 All pulse outputs SHALL be registered; no combinational path from in to any output.

Reset
REQ-027 On rst_n low: synchronisers and out SHALL be IDLE_LEVEL, all counters 0, FSM RELEASED, all pulse outputs and any_event 0.
REQ-028 Reset asserted mid-press SHALL abort the press with no pulses; after release of reset a held pin SHALL require a full debounce window and full hold threshold again.

Structure
REQ-029 Package key_debounce_pkg SHALL hold the FSM state enum (RELEASED, PRESSED, REPEAT).
REQ-030 One sub-module key_debounce_ch SHALL implement a single channel (sync, debounce, FSM); the top SHALL generate NUM_KEYS instances and the any_event register.

Verification (SIM: DEBOUNCE_W=2, HOLD_W=3, RATE_W=2, IDLE_LEVEL=1)
REQ-031 in[0] 1->0 held -> out[0] falls 6 edges later, falling[0] high 1 cycle, any_event high the next cycle.
REQ-032 in[1] low for 3 cycles then high -> out[1] stays 1, no pulses on any output.
REQ-033 in[0] held low 30 cycles -> long_press[0] and repeat[0] 8 cycles after falling[0], then repeat[0] every 4 cycles until release.
REQ-034 Release timed so out returns to 1 on a repeat terminal-count cycle -> rising pulsed, no repeat pulse, FSM RELEASED.
REQ-035 rst_n pulsed low during REPEAT with pin still low -> outputs reset immediately; falling again 6 edges after rst_n high, long_press 8 cycles later.
REQ-036 in[3:0] all 1->0 on same edge -> falling[3:0] = 4'hF in the same cycle, single any_event pulse.
